// File: rtl/riscv_pkg.sv
// riscv_pkg: shared fetch-stage types and parameter defaults.
// Used by inst_fetch and fetch_buf.
package riscv_pkg;

    localparam int          XLEN_DEF         = 32;
    localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        KILL
    } fetch_state_e;

endpackage

// File: rtl/fetch_buf.sv
// fetch_buf: one-entry instruction/PC holding buffer toward decode.
// Flush beats load, load beats pop.
module fetch_buf
    import riscv_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load_i,
    input  logic            pop_i,
    input  logic            flush_i,
    input  logic [XLEN-1:0] inst_i,
    input  logic [XLEN-1:0] pc_i,
    output logic            valid_o,
    output logic [XLEN-1:0] inst_o,
    output logic [XLEN-1:0] pc_o
);

    logic            valid_q, valid_d;
    logic [XLEN-1:0] inst_q, inst_d;
    logic [XLEN-1:0] pc_q, pc_d;

    always_comb begin
        valid_d = valid_q;
        inst_d  = inst_q;
        pc_d    = pc_q;
        if (pop_i) begin
            valid_d = 1'b0;
        end
        if (load_i) begin
            valid_d = 1'b1;
            inst_d  = inst_i;
            pc_d    = pc_i;
        end
        if (flush_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            inst_q  <= '0;
            pc_q    <= '0;
        end else begin
            valid_q <= valid_d;
            inst_q  <= inst_d;
            pc_q    <= pc_d;
        end
    end

    assign valid_o = valid_q;
    assign inst_o  = inst_q;
    assign pc_o    = pc_q;

endmodule

// File: rtl/inst_fetch.sv
// inst_fetch: single-outstanding instruction fetch with redirect/kill.
// Define INST_FETCH_MISALIGN_EN to add if_misalign and align imem_addr.
module inst_fetch
    import riscv_pkg::*;
#(
    parameter int              XLEN         = XLEN_DEF,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(RESET_VECTOR_DEF)
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_resp_valid,
    input  logic [XLEN-1:0] imem_resp_data,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [XLEN-1:0] if_inst,
    output logic [XLEN-1:0] if_pc,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc
`ifdef INST_FETCH_MISALIGN_EN
    ,
    output logic            if_misalign
`endif
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            buf_load;
    logic            buf_flush;
    logic            buf_pop;
    logic            buf_free;
    logic            in_flight;

    assign buf_pop  = if_valid && if_ready;
    assign buf_free = !if_valid || if_ready;

    // A request the memory still owes a response for after this edge.
    assign in_flight =
        ((state_q == REQ) && imem_req_ready) ||
        (((state_q == WAIT) || (state_q == KILL)) && !imem_resp_valid);

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        buf_load  = 1'b0;
        buf_flush = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (buf_free) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (imem_req_ready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (imem_resp_valid) begin
                    buf_load = 1'b1;
                    pc_d     = pc_q + XLEN'(4);
                    // Freshly loaded buffer is occupied next cycle.
                    state_d  = IDLE;
                end
            end
            KILL: begin
                if (imem_resp_valid) begin
                    state_d = REQ;
                end
            end
        endcase
        if (redirect_valid) begin
            pc_d      = redirect_pc;
            buf_load  = 1'b0;
            buf_flush = 1'b1;
            state_d   = in_flight ? KILL : REQ;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pc_q    <= RESET_VECTOR;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    fetch_buf #(
        .XLEN(XLEN)
    ) u_buf (
        .clk    (clk),
        .rst    (rst),
        .load_i (buf_load),
        .pop_i  (buf_pop),
        .flush_i(buf_flush),
        .inst_i (imem_resp_data),
        .pc_i   (pc_q),
        .valid_o(if_valid),
        .inst_o (if_inst),
        .pc_o   (if_pc)
    );

    assign imem_req_valid = (state_q == REQ);

`ifdef INST_FETCH_MISALIGN_EN
    assign imem_addr   = {pc_q[XLEN-1:2], 2'b00};
    assign if_misalign = if_valid && (if_pc[1:0] != 2'b00);
`else
    assign imem_addr   = pc_q;
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: vector table, corner sequences and random scoreboard.
// Build with INST_FETCH_MISALIGN_EN to also exercise if_misalign.
module tb_inst_fetch;

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_inst;
    logic [31:0] if_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
`ifdef INST_FETCH_MISALIGN_EN
    logic        if_misalign;
`endif

    int total = 0;
    int bad   = 0;

    inst_fetch dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_resp_valid(imem_resp_valid),
        .imem_resp_data (imem_resp_data),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_inst        (if_inst),
        .if_pc          (if_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
`ifdef INST_FETCH_MISALIGN_EN
        ,
        .if_misalign    (if_misalign)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory contents: a fixed function of the word address.
    function automatic logic [31:0] f(input logic [31:0] a);
        return ~a ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    task automatic drv(input logic rr, input logic rsv,
                       input logic [31:0] rsd, input logic ir,
                       input logic rdv, input logic [31:0] rdpc);
        imem_req_ready  = rr;
        imem_resp_valid = rsv;
        imem_resp_data  = rsd;
        if_ready        = ir;
        redirect_valid  = rdv;
        redirect_pc     = rdpc;
    endtask

    typedef struct packed {
        logic        rr;
        logic        rsv;
        logic [31:0] rsd;
        logic        ir;
        logic        rdv;
        logic [31:0] rdpc;
        logic        erv;
        logic [31:0] ea;
        logic        eiv;
        logic [31:0] ep;
    } vec_t;

    function automatic vec_t v(
        input logic rr, input logic rsv, input logic [31:0] rsd,
        input logic ir, input logic rdv, input logic [31:0] rdpc,
        input logic erv, input logic [31:0] ea,
        input logic eiv, input logic [31:0] ep);
        vec_t r;
        r.rr = rr; r.rsv = rsv; r.rsd = rsd;
        r.ir = ir; r.rdv = rdv; r.rdpc = rdpc;
        r.erv = erv; r.ea = ea; r.eiv = eiv; r.ep = ep;
        return r;
    endfunction

    vec_t tbl [25];

    // random-phase model state
    logic [31:0] exp_fetch, exp_deliv, pend_addr;
    logic        pend;
    int          pend_dly;
    int          deliv;
    logic        p_iv, p_ir, p_rv, p_rr, p_rdv;
    logic [31:0] p_pc, p_inst, p_addr;
    logic        hs, xfer;

    initial begin
        rst = 1'b1;
        drv(0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req_valid", {31'b0, imem_req_valid}, 0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_if_valid", {31'b0, if_valid}, 0);
        chk("rst_if_inst", if_inst, 0);
        chk("rst_if_pc", if_pc, 0);

        tbl[0]  = v(0,0,0,0,0,0,            0,32'h0,0,0);
        tbl[1]  = v(0,0,0,0,0,0,            1,32'h0,0,0);
        tbl[2]  = v(0,0,0,0,0,0,            1,32'h0,0,0);
        tbl[3]  = v(0,0,0,0,0,0,            1,32'h0,0,0);
        tbl[4]  = v(1,0,0,0,0,0,            1,32'h0,0,0);
        tbl[5]  = v(0,1,f(32'h0),0,0,0,     0,32'h0,0,0);
        tbl[6]  = v(0,0,0,1,0,0,            0,32'h4,1,32'h0);
        tbl[7]  = v(1,0,0,0,0,0,            1,32'h4,0,0);
        tbl[8]  = v(0,1,f(32'h4),0,0,0,     0,32'h4,0,0);
        tbl[9]  = v(0,0,0,0,0,0,            0,32'h8,1,32'h4);
        tbl[10] = v(0,0,0,0,0,0,            0,32'h8,1,32'h4);
        tbl[11] = v(0,0,0,0,0,0,            0,32'h8,1,32'h4);
        tbl[12] = v(0,0,0,0,0,0,            0,32'h8,1,32'h4);
        tbl[13] = v(0,0,0,0,0,0,            0,32'h8,1,32'h4);
        tbl[14] = v(0,0,0,1,0,0,            0,32'h8,1,32'h4);
        tbl[15] = v(1,0,0,0,0,0,            1,32'h8,0,0);
        tbl[16] = v(0,1,f(32'h8),0,0,0,     0,32'h8,0,0);
        tbl[17] = v(0,0,0,1,0,0,            0,32'hc,1,32'h8);
        tbl[18] = v(1,0,0,0,0,0,            1,32'hc,0,0);
        tbl[19] = v(0,0,0,0,1,32'h100,      0,32'hc,0,0);
        tbl[20] = v(0,1,f(32'hc),0,0,0,     0,32'h100,0,0);
        tbl[21] = v(1,0,0,0,0,0,            1,32'h100,0,0);
        tbl[22] = v(0,1,f(32'h100),0,0,0,   0,32'h100,0,0);
        tbl[23] = v(0,1,32'hBAD0_BAD0,1,1,32'h200,
                                            0,32'h104,1,32'h100);
        tbl[24] = v(0,0,0,0,0,0,            1,32'h200,0,0);

        rst = 1'b0;
        for (int i = 0; i < 25; i++) begin
            if (i > 0) @(negedge clk);
            drv(tbl[i].rr, tbl[i].rsv, tbl[i].rsd,
                tbl[i].ir, tbl[i].rdv, tbl[i].rdpc);
            #1;
            chk($sformatf("v%0d_req_valid", i),
                {31'b0, imem_req_valid}, {31'b0, tbl[i].erv});
            chk($sformatf("v%0d_addr", i), imem_addr, tbl[i].ea);
            chk($sformatf("v%0d_if_valid", i),
                {31'b0, if_valid}, {31'b0, tbl[i].eiv});
            if (tbl[i].eiv) begin
                chk($sformatf("v%0d_if_pc", i), if_pc, tbl[i].ep);
                chk($sformatf("v%0d_if_inst", i), if_inst, f(tbl[i].ep));
            end
        end

        // reset asserted while waiting for a response
        @(negedge clk);
        drv(1, 0, 0, 0, 0, 0);
        #1 chk("mr_req", {31'b0, imem_req_valid}, 1);
        @(negedge clk);
        drv(0, 0, 0, 0, 0, 0);
        #1 chk("mr_wait", {31'b0, imem_req_valid}, 0);
        #2 rst = 1'b1;
        #1;
        chk("mr_req_valid", {31'b0, imem_req_valid}, 0);
        chk("mr_addr", imem_addr, 32'h0);
        chk("mr_if_valid", {31'b0, if_valid}, 0);
        chk("mr_if_inst", if_inst, 0);
        chk("mr_if_pc", if_pc, 0);
        @(negedge clk);
        rst = 1'b0;
        drv(0, 1, f(32'h200), 0, 0, 0);
        #1 chk("late_rsp_if_valid", {31'b0, if_valid}, 0);
        @(negedge clk);
        drv(1, 0, 0, 0, 0, 0);
        #1;
        chk("rr_req_valid", {31'b0, imem_req_valid}, 1);
        chk("rr_addr", imem_addr, 32'h0);
        @(negedge clk);
        drv(0, 1, f(32'h0), 0, 0, 0);
        @(negedge clk);
`ifdef INST_FETCH_MISALIGN_EN
        drv(0, 0, 0, 0, 1, 32'h102);
`else
        drv(0, 0, 0, 0, 0, 0);
`endif
        #1;
        chk("rr_if_valid", {31'b0, if_valid}, 1);
        chk("rr_if_pc", if_pc, 32'h0);
        chk("rr_if_inst", if_inst, f(32'h0));
`ifdef INST_FETCH_MISALIGN_EN
        chk("ma_aligned_pc0", {31'b0, if_misalign}, 0);
        @(negedge clk);
        drv(1, 0, 0, 0, 0, 0);
        #1;
        chk("ma_req_valid", {31'b0, imem_req_valid}, 1);
        chk("ma_addr", imem_addr, 32'h100);
        chk("ma_flag_idle", {31'b0, if_misalign}, 0);
        @(negedge clk);
        drv(0, 1, f(32'h100), 0, 0, 0);
        @(negedge clk);
        drv(0, 0, 0, 0, 0, 0);
        #1;
        chk("ma_if_valid", {31'b0, if_valid}, 1);
        chk("ma_if_pc", if_pc, 32'h102);
        chk("ma_flag", {31'b0, if_misalign}, 1);
`endif

        // randomized run against a stream-level model
        rst = 1'b1;
        drv(0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_fetch = 32'h0;
        exp_deliv = 32'h0;
        pend = 1'b0;
        pend_dly = 0;
        pend_addr = 0;
        deliv = 0;
        p_iv = 0; p_ir = 0; p_rv = 0; p_rr = 0; p_rdv = 0;
        p_pc = 0; p_inst = 0; p_addr = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            imem_req_ready = ($urandom_range(0, 3) != 0);
            if_ready       = ($urandom_range(0, 2) != 0);
            redirect_valid = ($urandom_range(0, 19) == 0);
            redirect_pc    = 32'($urandom_range(0, 1023)) << 2;
            if (pend && pend_dly == 0) begin
                imem_resp_valid = 1'b1;
                imem_resp_data  = f(pend_addr);
            end else begin
                imem_resp_valid = 1'b0;
                imem_resp_data  = $urandom;
            end
            #1;
            if (p_iv && !p_ir && !p_rdv) begin
                chk("hold_if_valid", {31'b0, if_valid}, 1);
                chk("hold_if_pc", if_pc, p_pc);
                chk("hold_if_inst", if_inst, p_inst);
            end
            if (p_rv && !p_rr && !p_rdv) begin
                chk("hold_req_valid", {31'b0, imem_req_valid}, 1);
                chk("hold_addr", imem_addr, p_addr);
            end
            if (imem_req_valid && if_valid)
                chk("req_while_full", 32'h1, 32'h0);
`ifdef INST_FETCH_MISALIGN_EN
            chk("rnd_misalign", {31'b0, if_misalign}, 0);
`endif
            hs   = imem_req_valid && imem_req_ready;
            xfer = if_valid && if_ready && !redirect_valid;
            if (hs) begin
                chk("one_outstanding", {31'b0, pend}, 0);
                chk("fetch_addr", imem_addr, exp_fetch);
            end
            if (xfer) begin
                chk("deliv_pc", if_pc, exp_deliv);
                chk("deliv_inst", if_inst, f(exp_deliv));
                exp_deliv = exp_deliv + 4;
                deliv++;
            end
            if (imem_resp_valid) pend = 1'b0;
            else if (pend) pend_dly--;
            if (hs) begin
                pend      = 1'b1;
                pend_addr = imem_addr;
                pend_dly  = int'($urandom_range(0, 2));
                exp_fetch = exp_fetch + 4;
            end
            if (redirect_valid) begin
                exp_fetch = redirect_pc;
                exp_deliv = redirect_pc;
            end
            p_iv = if_valid; p_ir = if_ready; p_rdv = redirect_valid;
            p_rv = imem_req_valid; p_rr = imem_req_ready;
            p_pc = if_pc; p_inst = if_inst; p_addr = imem_addr;
        end
        chk("progress", (deliv >= 100) ? 32'h1 : 32'h0, 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
